// File: rtl/hex_counter_sseg_pkg.sv
// Shared constants for the hex counter demo: glyph table, button indices, digit count.
package hex_counter_sseg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam int BTN_INC = 0;
    localparam int BTN_DEC = 1;
    localparam int BTN_CLR = 2;

    // Active-low segments, bit order g,f,e,d,c,b,a; glyphs 0-9, A, b, C, d, E, F.
    localparam logic [6:0] SSEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_counter_sseg_button_debouncer.sv
// One push-button channel: 2-flop synchroniser, stable-level counter, rising-edge pulse.
module button_debouncer #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        level_d = level_q;
        cnt_d   = '0;
        // Any cycle where the input agrees with the accepted level restarts qualification.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_TC) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/hex_counter_sseg.sv
// Poncho board counter demo: 16-bit up/down hex counter on a 4-digit multiplexed display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant non-zero nibble.
module hex_counter_sseg
    import hex_counter_sseg_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 12000000,
    parameter int CLK_SND          = 12,
    parameter int DEBOUNCE_TIME_MS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hex,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam int DEB_N = CLK_FREQ_HZ / 1000 * DEBOUNCE_TIME_MS;

    logic [3:0]         btn_pulse;
    logic               unused_btn;
    logic [15:0]        count_q, count_d;
    logic [CLK_SND-1:0] refresh_q, refresh_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         sseg_q, sseg_d;
    logic [1:0]         sel;
    logic [3:0]         nibble;
    logic [6:0]         glyph;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_btn
        button_debouncer #(.CYCLES(DEB_N)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (hex[i]),
            .pulse   (btn_pulse[i])
        );
    end

    // hex[3] is a reserved button.
    assign unused_btn = btn_pulse[3];

    assign sel = refresh_q[CLK_SND-1 -: 2];

    always_comb begin
        count_d = count_q;
        if (btn_pulse[BTN_CLR]) begin
            count_d = '0;
        end else if (btn_pulse[BTN_INC] && btn_pulse[BTN_DEC]) begin
            count_d = count_q;
        end else if (btn_pulse[BTN_INC]) begin
            count_d = count_q + 16'd1;
        end else if (btn_pulse[BTN_DEC]) begin
            count_d = count_q - 16'd1;
        end

        refresh_d = refresh_q + 1'b1;

        nibble = 4'(count_q >> {sel, 2'b00});
        glyph  = SSEG_GLYPH[nibble];
`ifdef LEADING_ZERO_BLANK_EN
        // Digit 0 always shows so a zero count reads "0".
        if ((sel != 2'd0) && ((count_q >> {sel, 2'b00}) == 16'd0)) begin
            glyph = 7'h7F;
        end
`endif
        an_d   = ~(4'b0001 << sel);
        sseg_d = {~dp_in[sel], glyph};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            refresh_q <= '0;
            an_q      <= 4'b1111;
            sseg_q    <= 8'hFF;
        end else begin
            count_q   <= count_d;
            refresh_q <= refresh_d;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_hex_counter_sseg.sv
// Directed bench for hex_counter_sseg with N=10 debounce and a 16-cycle display frame.
module tb_hex_counter_sseg;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hex;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [7:0] sseg;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;
    logic [31:0] frame;

    hex_counter_sseg #(
        .CLK_FREQ_HZ      (1000),
        .CLK_SND          (4),
        .DEBOUNCE_TIME_MS (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hex   (hex),
        .dp_in (dp_in),
        .an    (an),
        .sseg  (sseg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [31:0] exp_frame(input logic [15:0] v, input logic [3:0] dp);
        logic [31:0] f;
        logic [6:0]  g;
        f = '0;
        for (int d = 0; d < 4; d++) begin
            g = glyph(v[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0 && (v >> (4*d)) == 16'd0) g = 7'h7F;
`endif
            f[8*d +: 8] = {~dp[d], g};
        end
        return f;
    endfunction

    // One full refresh period: every digit is lit for 4 consecutive cycles.
    task automatic capture_frame(output logic [31:0] f);
        f = '1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            case (an)
                4'b1110: f[7:0]   = sseg;
                4'b1101: f[15:8]  = sseg;
                4'b1011: f[23:16] = sseg;
                4'b0111: f[31:24] = sseg;
                default: ;
            endcase
        end
    endtask

    task automatic press(input logic [3:0] mask, input int hi);
        @(negedge clk);
        hex = mask;
        repeat (hi) @(negedge clk);
        hex = 4'b0000;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        capture_frame(frame);
        check(tag, frame, exp_frame(exp_cnt, dp_in));
    endtask

    initial begin
        reset = 1'b1;
        hex   = 4'b0000;
        dp_in = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_sseg", {24'd0, sseg}, 32'hFF);

        reset = 1'b0;
        @(negedge clk);
        check("first_an", {28'd0, an}, 32'hE);
        check("first_sseg", {24'd0, sseg}, 32'hC0);
        repeat (4) @(negedge clk);
        check("rot_d1", {28'd0, an}, 32'hD);
        repeat (4) @(negedge clk);
        check("rot_d2", {28'd0, an}, 32'hB);
        repeat (4) @(negedge clk);
        check("rot_d3", {28'd0, an}, 32'h7);

        exp_cnt = 16'h0000;
        repeat (3) press(4'b0001, 20);
        exp_cnt = 16'h0003;
        check_frame("inc3");

        press(4'b0100, 20);
        exp_cnt = 16'h0000;
        check_frame("clr");

        press(4'b0010, 20);
        exp_cnt = 16'hFFFF;
        check_frame("dec_wrap");

        press(4'b0001, 20);
        exp_cnt = 16'h0000;
        check_frame("inc_wrap");

        press(4'b0001, 5);
        check_frame("glitch");

        press(4'b0001, 200);
        exp_cnt = 16'h0001;
        check_frame("hold");

        repeat (164) press(4'b0001, 15);
        exp_cnt = 16'h00A5;
        check_frame("cnt_a5");

        press(4'b0101, 20);
        exp_cnt = 16'h0000;
        check_frame("clr_inc");

        press(4'b0001, 20);
        exp_cnt = 16'h0001;
        press(4'b0011, 20);
        check_frame("inc_dec");

        dp_in = 4'b0100;
        check_frame("dp2");
        dp_in = 4'b0000;

        // Reset lands on a press that has been held for 6 cycles.
        @(negedge clk);
        hex = 4'b0001;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_press_early", {20'd0, an, sseg}, {20'd0, 4'b1110, 8'hC0});
        repeat (15) @(negedge clk);
        check("rst_press_late", {20'd0, an, sseg}, {20'd0, 4'b1110, 8'hF9});
        repeat (40) @(negedge clk);
        hex = 4'b0000;
        repeat (20) @(negedge clk);
        exp_cnt = 16'h0001;
        check_frame("rst_press_once");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_counter_sseg.md
Name: hex_counter_sseg

Overview:
- 16-bit hexadecimal up/down counter driven by four push-buttons, shown on a 4-digit multiplexed seven-segment display.
- Top level of the Poncho board counter demo.
- Buttons are synchronised and debounced.
- Counter value is shown as 4 hex digits, digit 0 = least-significant nibble.

Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency in Hz.
- CLK_SND, 12, width of the display refresh counter; digit select = its top 2 bits, so each digit is lit for 2^(CLK_SND-2) cycles.
- DEBOUNCE_TIME_MS, 10, stable time in ms a button must hold before its new level is accepted.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- hex  input  4  raw active-high buttons: [0] increment, [1] decrement, [2] clear, [3] reserved (ignored).
- dp_in  input  4  active-high decimal-point request per digit; bit i drives digit i.
- an  output  4  active-low digit anodes; bit i = digit i.
- sseg  output  8  active-low segments: [7]=dp, [6:0]=g,f,e,d,c,b,a.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Input synchronisation:
  - Each hex bit passes through a 2-flop synchroniser, then a debouncer.
  - Debounce count N = CLK_FREQ_HZ/1000*DEBOUNCE_TIME_MS cycles.
  - The debounced level changes only after the synchronised input differs from it for N consecutive cycles.
  - Any bounce restarts the count.
- Button events:
  - A rising edge of a debounced level produces a one-cycle pulse.
  - Total input-to-pulse latency = 2 + N + 1 cycles.
- Counter update, evaluated each cycle in priority order:
  - Clear pulse: count <= 0.
  - Else increment and decrement pulses together: no change.
  - Else increment pulse: count + 1, wrapping FFFF -> 0000.
  - Else decrement pulse: count - 1, wrapping 0000 -> FFFF.
  - Holding a button gives exactly one step per press.
- Refresh:
  - CLK_SND-bit free-running counter, incremented every cycle.
  - sel = refresh[CLK_SND-1:CLK_SND-2].
- Display:
  - an = ~(1<<sel).
  - sseg[6:0] = active-low decode of nibble count[4*sel+3:4*sel], glyphs 0-9 and A,b,C,d,E,F.
  - sseg[7] = ~dp_in[sel].
  - Example encodings: '0' -> 7'b1000000, '1' -> 7'b1111001, 'F' -> 7'b0001110.
  - an and sseg are registered, i.e. one cycle after sel/count.
- Reset values:
  - count = 0, refresh = 0, all synchronisers and debouncers = 0.
  - an = 4'b1111, sseg = 8'hFF (display blank).
  - First cycle after reset release: an = 4'b1110, sseg = {~dp_in[0], 7'b1000000}.
- Reset asserted mid-press: debouncer state is cleared; the button must be re-qualified for N cycles, and a still-held button then produces one pulse.
- No combinational path from any input to any output.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined:
  - Digits above the most-significant non-zero nibble show segments off (sseg[6:0] = 7'h7F); dp is still honoured.
  - Digit 0 is always shown, so a count of 0 displays "0".
  - The anode still cycles normally.
- When undefined: all four digits are always shown, with leading zeros.

Decomposition:
- Package hex_counter_sseg_pkg:
  - 16-entry active-low seven-segment glyph constant array.
  - Button index constants: BTN_INC=0, BTN_DEC=1, BTN_CLR=2.
  - Digit count constant NUM_DIGITS=4.
- One natural sub-module: button_debouncer.
  - Synchroniser + stable counter + rising-edge pulse.
  - Parameterised by cycle count; instantiated 4 times.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=1000, DEBOUNCE_TIME_MS=10 (N=10), CLK_SND=4.
- Reset then release -> an=4'b1111 and sseg=8'hFF during reset; next cycle an=4'b1110, sseg=8'hC0 (dp_in=0); an rotates 1110,1101,1011,0111 every 4 cycles.
- Press hex[0] for 20 cycles, 3 times -> count=0003; digit 0 shows 8'hB0, digits 1-3 show 8'hC0 (or 8'hFF with LEADING_ZERO_BLANK_EN).
- From 0000, press hex[1] once -> count=FFFF, all digits 8'h8E; then press hex[0] -> wraps to 0000.
- Glitch hex[0] high for 5 cycles, then low -> no count change. Hold high for 200 cycles -> exactly +1.
- count=00A5, press hex[2] together with hex[0] -> count=0000. Press hex[0]+hex[1] together -> unchanged.
- dp_in=4'b0100 -> sseg[7]=0 only while an=4'b1011. Reset during a 6-cycle-old press -> count=0 and no pulse until 10 further stable cycles.
